dcache_responder: RTL and testbench
===================================

# dcache_responder

Cache-side responder for the datapath/cache request interface. It accepts instruction fetches and data load/store requests from the datapath request logic, holds each one for a fixed configurable latency, and services it from a unified word-addressed backing store. It answers with single-cycle `ihit`/`dhit` pulses plus load data, gives data requests priority, and signals `flushed` after `halt`. It stands in for the cache/memory side in single-core bring-up and datapath verification.

## Interface
- `LAT`, default 2: request-to-hit latency in cycles; legal range 1..15.
- `DEPTH_W`, default 8: log2 of backing-store depth in 32-bit words.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imemREN`  in  1  instruction fetch request, level.
- `imemaddr`  in  32  fetch byte address.
- `dmemREN`  in  1  data load request, level.
- `dmemWEN`  in  1  data store request, level.
- `dmemaddr`  in  32  data byte address.
- `dmemstore`  in  32  store data.
- `halt`  in  1  datapath halted.
- `ldWEN`  in  1  bench preload write enable.
- `ldaddr`  in  DEPTH_W  preload word index.
- `lddata`  in  32  preload data.
- `ihit`  out  1  fetch complete, one-cycle pulse.
- `imemload`  out  32  fetched word; valid only while `ihit` is high, 0 otherwise.
- `dhit`  out  1  data access complete, one-cycle pulse.
- `dmemload`  out  32  load data; valid only while `dhit` is high for a load, 0 otherwise.
- `flushed`  out  1  halt acknowledged; sticky until reset.

## Operation
- Backing store: 2^DEPTH_W x 32 register array.
  - Word index is `addr[DEPTH_W+1:2]`.
  - Bits [1:0] are ignored, so misaligned accesses round down.
  - Upper bits are ignored, so out-of-range addresses alias.
- States: IDLE, DBUSY, IBUSY, FLUSHED.
- IDLE:
  - If `halt` is high, go to FLUSHED. This takes priority over any request.
  - Otherwise, if `dmemREN` or `dmemWEN` is high, go to DBUSY. Latch the index, the op (`dmemWEN` wins if both are high; the access is then treated as a store), and `dmemstore`.
  - Otherwise, if `imemREN` is high, go to IBUSY and latch the fetch index.
  - Loading a BUSY state also loads the 4-bit counter `cnt = LAT-1`.
- DBUSY:
  - While `cnt > 0`, decrement each cycle.
  - When `cnt == 0`, assert `dhit` combinationally for that cycle.
  - For a load, `dmemload = mem[latched index]`.
  - For a store, write latched data to `mem[latched index]` at the closing edge.
  - Go to IDLE.
- IBUSY: same as DBUSY, but with `ihit` and `imemload`. Never writes.
- Abort rule: in DBUSY, if `dmemREN` and `dmemWEN` are both low, return to IDLE next edge with no hit and no write. IBUSY aborts the same way when `imemREN` is low.
- Latched address, op and data are used even if the inputs change mid-request. Only withdrawal aborts.
- FLUSHED: `flushed = 1`. All requests are ignored and the state is terminal until reset. `halt` seen during BUSY is honored only after the current access completes.
- Preload: when `ldWEN` is high, `mem[ldaddr] <= lddata` at the edge, in any state. If a store commit targets the same index on the same edge, the store wins.
- At most one access is outstanding. `ihit` and `dhit` are never high together.

## Timing
- Reset (async, `nRST` low):
  - State goes to IDLE and `cnt` to 0.
  - `ihit`, `dhit` and `flushed` are 0.
  - `imemload` and `dmemload` are 0.
  - All memory words are 0.
- Reset mid-request discards the access; no write occurs.
- A request sampled in IDLE in cycle A produces its hit in cycle A+LAT.
  - LAT=1: hit in A+1.
  - LAT=2: hit in A+2.
- After a hit the block is in IDLE in cycle A+LAT+1. A request still asserted then is accepted as a new request. Back-to-back fetches therefore complete every LAT+1 cycles.
- A store's data is readable by a load accepted in cycle A+LAT+1 or later.
- `flushed` rises one cycle after IDLE samples `halt`.

## Test plan
- Fetch latency, LAT=2: preload word 4 = 0x8C220004; hold `imemREN` with `imemaddr=0x10` from cycle 0 -> `ihit` is high in cycle 2 only, with `imemload=0x8C220004`; the next `ihit` is in cycle 5.
- Store then load: store 0xDEADBEEF to 0x40 and drop `dmemWEN` after `dhit`; then load 0x40 -> `dhit` in both cases, `dmemload=0xDEADBEEF`, and `dmemload=0` outside the hit cycle.
- Priority: `imemREN` and `dmemREN` both rise in cycle 0 -> `dhit` in cycle 2, `ihit` in cycle 5, never coincident.
- Abort: load accepted in cycle 0, `dmemREN` dropped in cycle 1 -> no `dhit`, block back in IDLE in cycle 2; same test for a store leaves memory unchanged.
- Halt: `halt` asserted in cycle 1 during an in-flight fetch -> `ihit` in cycle 2, `flushed` high from cycle 4 onward; a later `imemREN` gets no hit.
- LAT=1 plus reset: `nRST` pulsed low during DBUSY -> all outputs go to 0 immediately and the store is not committed; a post-reset load hits in cycle A+1.

Source files
------------

// File: rtl/dcache_responder.sv
`default_nettype none
// dcache_responder: fixed-latency cache-side responder for the datapath request interface,
// servicing fetches and loads/stores from a unified word-addressed backing store. Rev 1.0
module dcache_responder #(
  parameter int LAT     = 2,
  parameter int DEPTH_W = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               imemREN,
  input  logic [31:0]        imemaddr,
  input  logic               dmemREN,
  input  logic               dmemWEN,
  input  logic [31:0]        dmemaddr,
  input  logic [31:0]        dmemstore,
  input  logic               halt,
  input  logic               ldWEN,
  input  logic [DEPTH_W-1:0] ldaddr,
  input  logic [31:0]        lddata,
  output logic               ihit,
  output logic [31:0]        imemload,
  output logic               dhit,
  output logic [31:0]        dmemload,
  output logic               flushed
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DBUSY    = 2'd1;
  localparam logic [1:0] IBUSY    = 2'd2;
  localparam logic [1:0] FLUSHED  = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  localparam int         DEPTH    = 1 << DEPTH_W;

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DEPTH_W-1:0] idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        mem_q [DEPTH];

  logic               dreq;
  logic               withdrawn;
  logic               store_commit;
  logic [31:0]        rdata;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{imemaddr[31:DEPTH_W+2], imemaddr[1:0],
                              dmemaddr[31:DEPTH_W+2], dmemaddr[1:0]};

  assign dreq         = dmemREN | dmemWEN;
  assign rdata        = mem_q[idx_q];
  assign dhit         = (state_q == DBUSY) && dreq && (cnt_q == 4'd0);
  assign ihit         = (state_q == IBUSY) && imemREN && (cnt_q == 4'd0);
  assign dmemload     = (dhit && !wr_q) ? rdata : 32'd0;
  assign imemload     = ihit ? rdata : 32'd0;
  assign flushed      = (state_q == FLUSHED);
  assign store_commit = dhit && wr_q;

  // A withdrawn request aborts silently; this is checked before the hit condition.
  assign withdrawn = ((state_q == DBUSY) && !dreq) || ((state_q == IBUSY) && !imemREN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FLUSHED;
        end else if (dreq) begin
          state_d = DBUSY;
          cnt_d   = CNT_INIT;
          idx_d   = dmemaddr[DEPTH_W+1:2];
          wr_d    = dmemWEN;
          wdata_d = dmemstore;
        end else if (imemREN) begin
          state_d = IBUSY;
          cnt_d   = CNT_INIT;
          idx_d   = imemaddr[DEPTH_W+1:2];
          wr_d    = 1'b0;
        end
      end
      DBUSY, IBUSY: begin
        if (withdrawn || (cnt_q == 4'd0)) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FLUSHED: state_d = FLUSHED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Store commit is written last so it overrides a same-edge preload to the same word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      if (ldWEN) mem_q[ldaddr] <= lddata;
      if (store_commit) mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// tb_dcache_responder: directed self-checking bench; a LAT=2 and a LAT=1 instance share stimulus.
// Rev 1.0
module tb_dcache_responder;

  logic        CLK, nRST;
  logic        imemREN, dmemREN, dmemWEN, halt, ldWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore, lddata;
  logic [7:0]  ldaddr;
  logic        ihit2, dhit2, flushed2, ihit1, dhit1, flushed1;
  logic [31:0] imemload2, dmemload2, imemload1, dmemload1;

  int n_vec = 0;
  int n_err = 0;

  dcache_responder #(.LAT(2), .DEPTH_W(8)) u2 (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .ldWEN(ldWEN), .ldaddr(ldaddr), .lddata(lddata),
    .ihit(ihit2), .imemload(imemload2), .dhit(dhit2), .dmemload(dmemload2), .flushed(flushed2)
  );

  dcache_responder #(.LAT(1), .DEPTH_W(8)) u1 (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .ldWEN(ldWEN), .ldaddr(ldaddr), .lddata(lddata),
    .ihit(ihit1), .imemload(imemload1), .dhit(dhit1), .dmemload(dmemload1), .flushed(flushed1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic adv;
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    ldWEN = 1'b1; ldaddr = idx; lddata = data;
    adv();
    ldWEN = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    imemREN = 0; dmemREN = 0; dmemWEN = 0; halt = 0; ldWEN = 0;
    imemaddr = 0; dmemaddr = 0; dmemstore = 0; ldaddr = 0; lddata = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_vec++;
    if ({ihit2, dhit2, flushed2, ihit1, dhit1, flushed1} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b exp=000000", {ihit2, dhit2, flushed2, ihit1, dhit1, flushed1});
    end
    n_vec++;
    if ({imemload2, dmemload2, imemload1, dmemload1} !== 128'd0) begin
      n_err++;
      $display("FAIL reset_loads got=%h/%h/%h/%h exp=0", imemload2, dmemload2, imemload1, dmemload1);
    end
    #2 nRST = 1'b1;
    adv();
  endtask

  task automatic test_fetch;
    logic        exp_hit;
    logic [31:0] exp_data;
    preload(8'd4, 32'h8C220004);
    imemREN = 1'b1; imemaddr = 32'h10;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      exp_hit  = (c == 2) || (c == 5);
      exp_data = exp_hit ? 32'h8C220004 : 32'd0;
      n_vec++;
      if (ihit2 !== exp_hit || dhit2 !== 1'b0) begin
        n_err++;
        $display("FAIL fetch_hit c=%0d got ihit=%b dhit=%b exp ihit=%b dhit=0", c, ihit2, dhit2, exp_hit);
      end
      n_vec++;
      if (imemload2 !== exp_data) begin
        n_err++;
        $display("FAIL fetch_data c=%0d got=%h exp=%h", c, imemload2, exp_data);
      end
      adv();
    end
    imemREN = 1'b0;
  endtask

  task automatic test_store_load;
    logic        exp_hit;
    logic [31:0] exp_data;
    dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) dmemstore = 32'h0BADF00D;
      if (c == 3) begin
        dmemWEN = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h40;
      end
      @(negedge CLK);
      exp_hit  = (c == 2) || (c == 5);
      exp_data = (c == 5) ? 32'hDEADBEEF : 32'd0;
      n_vec++;
      if (dhit2 !== exp_hit || ihit2 !== 1'b0) begin
        n_err++;
        $display("FAIL stld_hit c=%0d got dhit=%b ihit=%b exp dhit=%b ihit=0", c, dhit2, ihit2, exp_hit);
      end
      n_vec++;
      if (dmemload2 !== exp_data) begin
        n_err++;
        $display("FAIL stld_data c=%0d got=%h exp=%h", c, dmemload2, exp_data);
      end
      adv();
    end
    dmemREN = 1'b0;
  endtask

  task automatic test_priority;
    logic exp_d, exp_i;
    imemREN = 1'b1; imemaddr = 32'h10; dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) dmemREN = 1'b0;
      @(negedge CLK);
      exp_d = (c == 2);
      exp_i = (c == 5);
      n_vec++;
      if (dhit2 !== exp_d || ihit2 !== exp_i) begin
        n_err++;
        $display("FAIL prio_hit c=%0d got d=%b i=%b exp d=%b i=%b", c, dhit2, ihit2, exp_d, exp_i);
      end
      n_vec++;
      if (dmemload2 !== (exp_d ? 32'hDEADBEEF : 32'd0) || imemload2 !== (exp_i ? 32'h8C220004 : 32'd0)) begin
        n_err++;
        $display("FAIL prio_data c=%0d got d=%h i=%h", c, dmemload2, imemload2);
      end
      adv();
    end
    imemREN = 1'b0;
  endtask

  task automatic test_abort;
    logic        exp_hit;
    logic [31:0] exp_data;
    // Aborted load: IDLE again in c2, so a fetch raised there hits in c4.
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) dmemREN = 1'b0;
      if (c == 2) begin imemREN = 1'b1; imemaddr = 32'h10; end
      @(negedge CLK);
      exp_hit = (c == 4);
      n_vec++;
      if (dhit2 !== 1'b0 || ihit2 !== exp_hit) begin
        n_err++;
        $display("FAIL abort_ld c=%0d got dhit=%b ihit=%b exp dhit=0 ihit=%b", c, dhit2, ihit2, exp_hit);
      end
      adv();
    end
    imemREN = 1'b0;
    // Aborted store, then an aliased misaligned load of the same word.
    dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) dmemWEN = 1'b0;
      if (c == 2) begin dmemREN = 1'b1; dmemaddr = 32'h443; end
      @(negedge CLK);
      exp_hit  = (c == 4);
      exp_data = exp_hit ? 32'hDEADBEEF : 32'd0;
      n_vec++;
      if (dhit2 !== exp_hit || dmemload2 !== exp_data) begin
        n_err++;
        $display("FAIL abort_st c=%0d got dhit=%b data=%h exp dhit=%b data=%h", c, dhit2, dmemload2, exp_hit, exp_data);
      end
      adv();
    end
    dmemREN = 1'b0;
  endtask

  task automatic test_halt;
    logic exp_hit, exp_fl;
    imemREN = 1'b1; imemaddr = 32'h10;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) halt = 1'b1;
      if (c == 5) halt = 1'b0;
      @(negedge CLK);
      exp_hit = (c == 2);
      exp_fl  = (c >= 4);
      n_vec++;
      if (ihit2 !== exp_hit || flushed2 !== exp_fl || dhit2 !== 1'b0) begin
        n_err++;
        $display("FAIL halt c=%0d got ihit=%b fl=%b dhit=%b exp ihit=%b fl=%b dhit=0", c, ihit2, flushed2, dhit2, exp_hit, exp_fl);
      end
      adv();
    end
    imemREN = 1'b0;
  endtask

  task automatic test_lat1_reset;
    nRST = 1'b0; #2 nRST = 1'b1;
    adv();
    dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hCAFEF00D;
    @(negedge CLK);
    n_vec++;
    if (dhit1 !== 1'b0 || flushed1 !== 1'b0) begin
      n_err++;
      $display("FAIL l1_st_c0 got dhit=%b fl=%b exp 0/0", dhit1, flushed1);
    end
    adv();
    #1;
    n_vec++;
    if (dhit1 !== 1'b1) begin
      n_err++;
      $display("FAIL l1_st_hit got=%b exp=1", dhit1);
    end
    nRST = 1'b0;
    #1;
    n_vec++;
    if ({dhit1, ihit1, flushed1, dhit2} !== 4'b0 || dmemload1 !== 32'd0 || imemload1 !== 32'd0) begin
      n_err++;
      $display("FAIL l1_rst_outs got flags=%b dl=%h il=%h exp 0", {dhit1, ihit1, flushed1, dhit2}, dmemload1, imemload1);
    end
    dmemWEN = 1'b0;
    #1 nRST = 1'b1;
    adv();
    // Word 0x10 must read 0: memory cleared by reset and the interrupted store never landed.
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_vec++;
      if (dhit1 !== (c == 1) || dmemload1 !== 32'd0) begin
        n_err++;
        $display("FAIL l1_ld c=%0d got dhit=%b data=%h exp dhit=%b data=0", c, dhit1, dmemload1, (c == 1));
      end
      adv();
    end
    dmemREN = 1'b0;
    dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hA5A5A5A5;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin ldWEN = 1'b1; ldaddr = 8'h10; lddata = 32'h5A5A5A5A; end
      if (c == 2) begin ldWEN = 1'b0; dmemWEN = 1'b0; dmemREN = 1'b1; end
      @(negedge CLK);
      n_vec++;
      if (dhit1 !== (c == 1 || c == 3) || dmemload1 !== ((c == 3) ? 32'hA5A5A5A5 : 32'd0)) begin
        n_err++;
        $display("FAIL l1_collide c=%0d got dhit=%b data=%h", c, dhit1, dmemload1);
      end
      adv();
    end
    dmemREN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_abort();
    test_halt();
    test_lat1_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
